arranque_ctrl: RTL and testbench



---
 rtl/arranque_ctrl_pkg.sv | 33 +++
 rtl/arranque_ctrl_if.sv | 36 +++
 rtl/arranque_ctrl_antirrebote.sv | 45 ++++
 rtl/arranque_ctrl.sv | 116 +++++++++++
 tb/tb_arranque_ctrl.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/arranque_ctrl_pkg.sv
// arranque_ctrl shared package: state encoding, defaults, mode constants.
// Optional input synchronizer is selected with SINCRONIZADOR_EN.
package arranque_ctrl_pkg;

    localparam int N = 6;

    typedef enum logic [N-1:0] {
        ST_REPOSO = 6'b000001,
        ST_FILTRO = 6'b000010,
        ST_PULSO  = 6'b000100,
        ST_ESPERA = 6'b001000,
        ST_ACTIVO = 6'b010000,
        ST_FALLA  = 6'b100000
    } estado_t;

    localparam int DEB_CICLOS_DEF  = 4;
    localparam int ANCHO_PULSO_DEF = 2;
    localparam int TIMEOUT_DEF     = 8;
    localparam int REINTENTOS_DEF  = 2;

    localparam logic MODO_GAS  = 1'b1;
    localparam logic MODO_ELEC = 1'b0;

    // Feedback line that confirms engagement for the latched mode.
    function automatic logic retro_esperada(
        input logic modo,
        input logic m1,
        input logic m2
    );
        return (modo == MODO_GAS) ? m2 : m1;
    endfunction

endpackage

// File: rtl/arranque_ctrl_if.sv
// arranque_ctrl command interface toward the motor controller.
// master = start sequencer, slave = driver panel / motor controller side.
interface arranque_ctrl_if;

    logic BOTON;
    logic SELECTOR;
    logic MOTOR1;
    logic MOTOR2;
    logic ARRANQUE;
    logic MODO;
    logic LISTO;
    logic FALLA;

    modport master (
        input  BOTON,
        input  SELECTOR,
        input  MOTOR1,
        input  MOTOR2,
        output ARRANQUE,
        output MODO,
        output LISTO,
        output FALLA
    );

    modport slave (
        output BOTON,
        output SELECTOR,
        output MOTOR1,
        output MOTOR2,
        input  ARRANQUE,
        input  MODO,
        input  LISTO,
        input  FALLA
    );

endinterface

// File: rtl/arranque_ctrl_antirrebote.sv
// arranque_ctrl button debouncer; one-cycle aceptado strobe to the FSM.
// With SINCRONIZADOR_EN the button first passes a 2-flop synchronizer.
module arranque_ctrl_antirrebote
    import arranque_ctrl_pkg::*;
#(
    parameter int DEB_CICLOS = DEB_CICLOS_DEF
) (
    input  logic CLK,
    input  logic REINICIO,
    input  logic boton,
    input  logic habilitar,
    output logic boton_s,
    output logic aceptado
);

    logic [7:0] cnt;

`ifdef SINCRONIZADOR_EN
    logic [1:0] sinc;

    // Two-stage synchronizer for the asynchronous button.
    always_ff @(posedge CLK or negedge REINICIO) begin
        if (!REINICIO) sinc <= 2'b00;
        else           sinc <= {sinc[0], boton};
    end

    assign boton_s = sinc[1];
`else
    assign boton_s = boton;
`endif

    assign aceptado = habilitar & boton_s
                    & (cnt == 8'(DEB_CICLOS - 1));

    // Count consecutive high cycles while the FSM is filtering.
    always_ff @(posedge CLK or negedge REINICIO) begin
        if (!REINICIO)
            cnt <= 8'd0;
        else if (!boton_s || !habilitar || aceptado)
            cnt <= 8'd0;
        else
            cnt <= cnt + 8'd1;
    end

endmodule

// File: rtl/arranque_ctrl.sv
// arranque_ctrl: driver-side start sequencer (debounce, pulse, confirm).
// Define SINCRONIZADOR_EN to synchronize BOTON (+2 cycles latency).
module arranque_ctrl
    import arranque_ctrl_pkg::*;
#(
    parameter int DEB_CICLOS  = DEB_CICLOS_DEF,
    parameter int ANCHO_PULSO = ANCHO_PULSO_DEF,
    parameter int TIMEOUT     = TIMEOUT_DEF,
    parameter int REINTENTOS  = REINTENTOS_DEF
) (
    input  logic           CLK,
    input  logic           REINICIO,
    arranque_ctrl_if.master bus
);

    estado_t    estado, estado_sig;
    logic [7:0] cnt, cnt_sig;
    logic [2:0] intentos, intentos_sig;
    logic       modo_reg, modo_sig;
    logic       boton_s;
    logic       aceptado;
    logic       retro;

    arranque_ctrl_antirrebote #(
        .DEB_CICLOS (DEB_CICLOS)
    ) u_antirrebote (
        .CLK       (CLK),
        .REINICIO  (REINICIO),
        .boton     (bus.BOTON),
        .habilitar (estado == ST_FILTRO),
        .boton_s   (boton_s),
        .aceptado  (aceptado)
    );

    assign retro = retro_esperada(modo_reg, bus.MOTOR1, bus.MOTOR2);

    // State, shared counter, attempt count and latched mode.
    always_ff @(posedge CLK or negedge REINICIO) begin
        if (!REINICIO) begin
            estado   <= ST_REPOSO;
            cnt      <= 8'd0;
            intentos <= 3'd0;
            modo_reg <= 1'b0;
        end else begin
            estado   <= estado_sig;
            cnt      <= cnt_sig;
            intentos <= intentos_sig;
            modo_reg <= modo_sig;
        end
    end

    // Next-state logic; illegal encodings fall back to REPOSO.
    always_comb begin
        estado_sig   = estado;
        cnt_sig      = cnt;
        intentos_sig = intentos;
        modo_sig     = modo_reg;
        case (estado)
            ST_REPOSO: begin
                if (boton_s) begin
                    estado_sig   = ST_FILTRO;
                    cnt_sig      = 8'd0;
                    intentos_sig = 3'd0;
                end
            end
            ST_FILTRO: begin
                if (!boton_s) begin
                    estado_sig = ST_REPOSO;
                end else if (aceptado) begin
                    estado_sig = ST_PULSO;
                    modo_sig   = bus.SELECTOR;
                    cnt_sig    = 8'd0;
                end
            end
            ST_PULSO: begin
                if (cnt == 8'(ANCHO_PULSO - 1)) begin
                    estado_sig = ST_ESPERA;
                    cnt_sig    = 8'd0;
                end else begin
                    cnt_sig = cnt + 8'd1;
                end
            end
            ST_ESPERA: begin
                if (retro) begin
                    estado_sig = ST_ACTIVO;
                end else if (cnt == 8'(TIMEOUT - 1)) begin
                    if (intentos < 3'(REINTENTOS)) begin
                        estado_sig   = ST_PULSO;
                        intentos_sig = intentos + 3'd1;
                        cnt_sig      = 8'd0;
                    end else begin
                        estado_sig = ST_FALLA;
                    end
                end else begin
                    cnt_sig = cnt + 8'd1;
                end
            end
            ST_ACTIVO: begin
                if (!bus.MOTOR1 && !bus.MOTOR2)
                    estado_sig = ST_REPOSO;
            end
            ST_FALLA: begin
                estado_sig = ST_FALLA;
            end
            default: begin
                estado_sig = ST_REPOSO;
            end
        endcase
    end

    assign bus.ARRANQUE = (estado == ST_PULSO);
    assign bus.LISTO    = (estado == ST_ACTIVO);
    assign bus.FALLA    = (estado == ST_FALLA);
    assign bus.MODO     = modo_reg;

endmodule

// File: tb/tb_arranque_ctrl.sv
// arranque_ctrl testbench: pulse scoreboard plus direct output checks.
// Honors SINCRONIZADOR_EN for the extra button latency.
module tb_arranque_ctrl;

    localparam int DEB   = 4;
    localparam int ANCHO = 2;
    localparam int TOUT  = 8;
    localparam int REINT = 2;
`ifdef SINCRONIZADOR_EN
    localparam int S = 2;
`else
    localparam int S = 0;
`endif

    typedef struct {
        int   cyc;
        logic modo;
    } pulso_t;

    logic CLK = 1'b0;
    logic REINICIO;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_ok = 0;
    pulso_t q[$];

    arranque_ctrl_if bus ();

    arranque_ctrl #(
        .DEB_CICLOS  (DEB),
        .ANCHO_PULSO (ANCHO),
        .TIMEOUT     (TOUT),
        .REINTENTOS  (REINT)
    ) dut (
        .CLK      (CLK),
        .REINICIO (REINICIO),
        .bus      (bus)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_ok++;
        else $display("FAIL %s got=%0d exp=%0d at cyc %0d",
                      tag, got, exp, cyc);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    function automatic int salidas();
        return {28'd0, bus.ARRANQUE, bus.MODO, bus.LISTO, bus.FALLA};
    endfunction

    // Monitor: pop expected pulse on each ARRANQUE rise, check width.
    logic   prev_arr = 1'b0;
    int     ancho_obs = 0;
    pulso_t e;
    always @(negedge CLK) begin
        if (bus.ARRANQUE === 1'b1) begin
            if (!prev_arr) begin
                ancho_obs = 1;
                if (q.size() == 0) begin
                    check("pulso_espurio", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("inicio_pulso", cyc, e.cyc);
                    check("modo_pulso", int'(bus.MODO), int'(e.modo));
                end
            end else begin
                ancho_obs++;
            end
        end else if (prev_arr) begin
            check("ancho_pulso", ancho_obs, ANCHO);
        end
        prev_arr = (bus.ARRANQUE === 1'b1);
    end

    int c, p0, f;

    initial begin
        REINICIO     = 1'b0;
        bus.BOTON    = 1'b0;
        bus.SELECTOR = 1'b0;
        bus.MOTOR1   = 1'b0;
        bus.MOTOR2   = 1'b0;
        step(3);
        check("reset_salidas", salidas(), 0);
        REINICIO = 1'b1;
        step(2);

        // Short press is rejected.
        bus.BOTON = 1'b1;
        step(3);
        bus.BOTON = 1'b0;
        step(12);
        check("glitch_salidas", salidas(), 0);

        // Gas start, MOTOR2 confirms three cycles after pulse ends.
        c = cyc;
        bus.BOTON    = 1'b1;
        bus.SELECTOR = 1'b1;
        p0 = c + 1 + DEB + S;
        q.push_back('{p0, 1'b1});
        step(p0 + ANCHO + 2 - cyc);
        check("listo_previo", int'(bus.LISTO), 0);
        bus.MOTOR2 = 1'b1;
        step(1);
        check("listo_gas", int'(bus.LISTO), 1);
        check("arranque_activo", int'(bus.ARRANQUE), 0);
        bus.SELECTOR = 1'b0;
        step(3);
        check("activo_ignora", int'(bus.LISTO), 1);

        // Controller reset: both feedbacks low drops LISTO.
        bus.MOTOR2 = 1'b0;
        bus.BOTON  = 1'b0;
        step(1);
        check("listo_cae", int'(bus.LISTO), 0);
        step(6);
        check("reposo_salidas", salidas(), 4'b0100);

        // Electric, no valid feedback: three pulses then FALLA.
        c = cyc;
        bus.BOTON    = 1'b1;
        bus.SELECTOR = 1'b0;
        p0 = c + 1 + DEB + S;
        for (int k = 0; k <= REINT; k++)
            q.push_back('{p0 + k * (ANCHO + TOUT), 1'b0});
        step(p0 - cyc);
        bus.SELECTOR = 1'b1;
        bus.MOTOR2   = 1'b1;
        step(1);
        check("modo_congelado_pulso", int'(bus.MODO), 0);
        step(3);
        bus.SELECTOR = 1'b0;
        step(1);
        bus.SELECTOR = 1'b1;
        check("modo_congelado_espera", int'(bus.MODO), 0);
        check("motor_ajeno", int'(bus.LISTO), 0);
        f = p0 + (REINT + 1) * (ANCHO + TOUT);
        step(f - 1 - cyc);
        check("falla_previa", int'(bus.FALLA), 0);
        step(1);
        check("falla", int'(bus.FALLA), 1);
        bus.BOTON = 1'b0;
        step(10);
        check("falla_pegada", salidas(), 4'b0001);

        // Asynchronous reset in ESPERA.
        REINICIO = 1'b0;
        bus.MOTOR2 = 1'b0;
        step(2);
        REINICIO = 1'b1;
        step(2);
        c = cyc;
        bus.BOTON    = 1'b1;
        bus.SELECTOR = 1'b1;
        p0 = c + 1 + DEB + S;
        q.push_back('{p0, 1'b1});
        step(p0 + ANCHO + 3 - cyc);
        bus.BOTON = 1'b0;
        check("espera_pre_reset", salidas(), 4'b0100);
        #2;
        REINICIO = 1'b0;
        #1;
        check("reset_async", salidas(), 0);
        step(2);
        REINICIO = 1'b1;
        step(20);
        check("post_reset", salidas(), 0);

        check("pendientes", q.size(), 0);
        $display("%0d/%0d checks passed", n_ok, n_chk);
        $finish;
    end

endmodule
